// File: rtl/func_if_pkg.sv
// Shared field layout and FSM encoding for the function-kernel tx request/response protocol.
package func_if_pkg;

  localparam int REQ_W        = 64;
  localparam int RESP_W       = 64;
  localparam int LEN_W        = 32;
  localparam int ID_W         = 16;
  localparam int REQ_LEN_LSB  = 0;
  localparam int REQ_ID_LSB   = 32;
  localparam int RESP_LEN_LSB = 0;
  localparam int RESP_ID_LSB  = 32;
  localparam int RESP_ERR_BIT = 48;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RESP = 2'd1,
    ST_DATA = 2'd2
  } tx_state_e;

  function automatic logic [RESP_W-1:0] pack_resp(input logic [LEN_W-1:0] len,
                                                   input logic [ID_W-1:0]  id,
                                                   input logic             err);
    logic [RESP_W-1:0] r;
    r = '0;
    r[RESP_LEN_LSB +: LEN_W] = len;
    r[RESP_ID_LSB +: ID_W]   = id;
    r[RESP_ERR_BIT]          = err;
    return r;
  endfunction

endpackage

// File: rtl/func_tx_fifo.sv
// First-word fall-through FIFO; full/empty come from the registered count so the
// write-side ready never depends combinationally on the read side.
module func_tx_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 512
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_wr_en,
  input  logic [WIDTH-1:0]           i_wr_data,
  output logic                       o_full,
  input  logic                       i_rd_en,
  output logic [WIDTH-1:0]           o_rd_data,
  output logic                       o_empty,
  output logic [$clog2(DEPTH):0]     o_count
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0] r_count, w_count_nxt;
  logic             r_full;
  logic             w_wr, w_rd;

  assign w_wr = i_wr_en & ~r_full;
  assign w_rd = i_rd_en & (r_count != '0);

  always_comb begin
    w_count_nxt = r_count;
    if (w_wr && !w_rd)      w_count_nxt = r_count + CNT_W'(1);
    else if (!w_wr && w_rd) w_count_nxt = r_count - CNT_W'(1);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_rd) r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == CNT_W'(DEPTH));
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= i_wr_data;
  end

  assign o_rd_data = r_mem[r_rd_ptr];
  assign o_full    = r_full;
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;

endmodule

// File: rtl/func_tx_responder.sv
// Far-end responder for a kernel tx port: grants requests, absorbs the granted beats
// into a FIFO and replays them as a tlast-framed stream, with status counters.
module func_tx_responder
  import func_if_pkg::*;
#(
  parameter int          DATA_W     = 32,
  parameter int          FIFO_DEPTH = 512,
  parameter logic [31:0] MAX_LEN    = 32'h0040_0000
) (
  input  logic              ap_clk,
  input  logic              ap_rst_n,
  input  logic [63:0]       s_axis_tx_req_tdata,
  input  logic              s_axis_tx_req_tvalid,
  output logic              s_axis_tx_req_tready,
  output logic [63:0]       m_axis_tx_resp_tdata,
  output logic              m_axis_tx_resp_tvalid,
  input  logic              m_axis_tx_resp_tready,
  input  logic [DATA_W-1:0] s_axis_tx_data_tdata,
  input  logic              s_axis_tx_data_tvalid,
  output logic              s_axis_tx_data_tready,
  output logic [DATA_W-1:0] m_axis_out_tdata,
  output logic              m_axis_out_tvalid,
  output logic              m_axis_out_tlast,
  input  logic              m_axis_out_tready,
  input  logic              clear_stat,
  output logic [31:0]       frame_count,
  output logic [15:0]       error_count,
  output logic              protocol_fault,
  output logic [2:0]        stall_flags
);

  localparam int BPB    = DATA_W / 8;
  localparam int BPB_LG = $clog2(BPB);
  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;

  tx_state_e         r_state, w_next;
  logic              r_alive;
  logic [LEN_W-1:0]  r_len;
  logic [ID_W-1:0]   r_id;
  logic              r_err;
  logic [31:0]       r_beats;
  logic [31:0]       r_frame_count;
  logic [15:0]       r_error_count;
  logic              r_fault;

  logic [LEN_W-1:0]  w_req_len;
  logic [ID_W-1:0]   w_req_id;
  logic              w_req_err;
  logic [LEN_W:0]    w_len_rnd, w_req_beats;
  logic              w_req_rdy, w_resp_vld, w_data_rdy;
  logic              w_req_hs, w_resp_hs, w_data_hs, w_last_beat;
  logic              w_fifo_full, w_fifo_empty;
  logic [DATA_W:0]   w_fifo_rd_data;
  logic [CNT_W-1:0]  w_fifo_count;
  logic              w_unused_ok;

  assign w_req_len   = s_axis_tx_req_tdata[REQ_LEN_LSB +: LEN_W];
  assign w_req_id    = s_axis_tx_req_tdata[REQ_ID_LSB +: ID_W];
  assign w_req_err   = (w_req_len == '0) || (w_req_len > MAX_LEN);
  // Round up to whole beats; the carry bit only matters for illegal lengths.
  assign w_len_rnd   = {1'b0, w_req_len} + (LEN_W+1)'(BPB - 1);
  assign w_req_beats = w_len_rnd >> BPB_LG;

  assign w_req_hs    = s_axis_tx_req_tvalid & w_req_rdy;
  assign w_resp_hs   = w_resp_vld & m_axis_tx_resp_tready;
  assign w_data_hs   = s_axis_tx_data_tvalid & w_data_rdy;
  assign w_last_beat = (r_beats == 32'd1);

  always_comb begin
    w_next     = r_state;
    w_req_rdy  = 1'b0;
    w_resp_vld = 1'b0;
    w_data_rdy = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_req_rdy = r_alive;
        if (w_req_hs) w_next = ST_RESP;
      end
      ST_RESP: begin
        w_resp_vld = 1'b1;
        if (w_resp_hs) w_next = r_err ? ST_IDLE : ST_DATA;
      end
      ST_DATA: begin
        w_data_rdy = ~w_fifo_full;
        if (w_data_hs && w_last_beat) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_state <= ST_IDLE;
      r_alive <= 1'b0;
    end else begin
      r_state <= w_next;
      r_alive <= 1'b1;
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_len   <= '0;
      r_id    <= '0;
      r_err   <= 1'b0;
      r_beats <= '0;
    end else if (w_req_hs) begin
      r_len   <= w_req_len;
      r_id    <= w_req_id;
      r_err   <= w_req_err;
      r_beats <= w_req_err ? 32'd0 : w_req_beats[31:0];
    end else if (w_data_hs) begin
      r_beats <= r_beats - 32'd1;
    end
  end

  // clear_stat takes priority over any increment or fault in the same cycle
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_frame_count <= '0;
      r_error_count <= '0;
      r_fault       <= 1'b0;
    end else if (clear_stat) begin
      r_frame_count <= '0;
      r_error_count <= '0;
      r_fault       <= 1'b0;
    end else begin
      if (w_data_hs && w_last_beat) r_frame_count <= r_frame_count + 32'd1;
      if (w_resp_hs && r_err && r_error_count != 16'hFFFF)
        r_error_count <= r_error_count + 16'd1;
      if (s_axis_tx_data_tvalid && r_state != ST_DATA) r_fault <= 1'b1;
    end
  end

  func_tx_fifo #(
    .WIDTH (DATA_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk     (ap_clk),
    .i_rst_n   (ap_rst_n),
    .i_wr_en   (w_data_hs),
    .i_wr_data ({w_last_beat, s_axis_tx_data_tdata}),
    .o_full    (w_fifo_full),
    .i_rd_en   (m_axis_out_tready & ~w_fifo_empty),
    .o_rd_data (w_fifo_rd_data),
    .o_empty   (w_fifo_empty),
    .o_count   (w_fifo_count)
  );

  assign s_axis_tx_req_tready  = w_req_rdy;
  assign m_axis_tx_resp_tvalid = w_resp_vld;
  assign m_axis_tx_resp_tdata  = pack_resp(r_err ? '0 : r_len, r_id, r_err);
  assign s_axis_tx_data_tready = w_data_rdy;

  assign m_axis_out_tvalid = (w_fifo_count != '0);
  assign m_axis_out_tdata  = w_fifo_rd_data[DATA_W-1:0];
  assign m_axis_out_tlast  = w_fifo_rd_data[DATA_W];

  assign frame_count    = r_frame_count;
  assign error_count    = r_error_count;
  assign protocol_fault = r_fault;

  assign stall_flags = {s_axis_tx_data_tvalid & ~w_data_rdy,
                        w_resp_vld & ~m_axis_tx_resp_tready,
                        s_axis_tx_req_tvalid & ~w_req_rdy};

  assign w_unused_ok = ^{s_axis_tx_req_tdata[63:48], w_req_beats[LEN_W]};

endmodule

// File: tb/tb_func_tx_responder.sv
// Directed bench for func_tx_responder with a transaction-level reference model
// checked every cycle on the falling edge.
module tb_func_tx_responder;

  localparam int          DW    = 32;
  localparam int          DEPTH = 16;
  localparam logic [31:0] MAXL  = 32'h0040_0000;

  logic          ap_clk = 1'b0;
  logic          ap_rst_n;
  logic [63:0]   req_tdata;
  logic          req_tvalid, req_tready;
  logic [63:0]   resp_tdata;
  logic          resp_tvalid, resp_tready;
  logic [DW-1:0] din_tdata;
  logic          din_tvalid, din_tready;
  logic [DW-1:0] out_tdata;
  logic          out_tvalid, out_tlast, out_tready;
  logic          clear_stat;
  logic [31:0]   frame_count;
  logic [15:0]   error_count;
  logic          protocol_fault;
  logic [2:0]    stall_flags;

  func_tx_responder #(.DATA_W(DW), .FIFO_DEPTH(DEPTH), .MAX_LEN(MAXL)) dut (
    .ap_clk                (ap_clk),
    .ap_rst_n              (ap_rst_n),
    .s_axis_tx_req_tdata   (req_tdata),
    .s_axis_tx_req_tvalid  (req_tvalid),
    .s_axis_tx_req_tready  (req_tready),
    .m_axis_tx_resp_tdata  (resp_tdata),
    .m_axis_tx_resp_tvalid (resp_tvalid),
    .m_axis_tx_resp_tready (resp_tready),
    .s_axis_tx_data_tdata  (din_tdata),
    .s_axis_tx_data_tvalid (din_tvalid),
    .s_axis_tx_data_tready (din_tready),
    .m_axis_out_tdata      (out_tdata),
    .m_axis_out_tvalid     (out_tvalid),
    .m_axis_out_tlast      (out_tlast),
    .m_axis_out_tready     (out_tready),
    .clear_stat            (clear_stat),
    .frame_count           (frame_count),
    .error_count           (error_count),
    .protocol_fault        (protocol_fault),
    .stall_flags           (stall_flags)
  );

  always #5 ap_clk = ~ap_clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic timeout(input string nm);
    n_chk++;
    n_err++;
    $display("FAIL %s: timed out at %0t", nm, $time);
  endtask

  // Reference model: transaction-level view of what the responder owes the outside world.
  logic [DW:0] mq[$];
  bit          m_pend;
  logic [63:0] m_resp;
  bit          m_resp_err;
  longint      m_beats_grant;
  longint      m_left;
  longint      m_frames;
  int          m_errs;
  bit          m_fault;
  logic [63:0] last_resp;
  logic [DW:0] last_out;

  always @(negedge ap_clk) begin
    if (!ap_rst_n) begin
      mq.delete();
      m_pend = 0; m_left = 0; m_frames = 0; m_errs = 0; m_fault = 0;
    end else begin
      chk("out_tvalid", {63'd0, out_tvalid}, {63'd0, mq.size() != 0});
      if (out_tvalid && out_tready && mq.size() != 0) begin
        chk("out_beat", {31'd0, out_tlast, out_tdata}, {31'd0, mq[0]});
        last_out = {out_tlast, out_tdata};
        void'(mq.pop_front());
      end
      chk("frame_count", {32'd0, frame_count}, m_frames[63:0] & 64'hFFFF_FFFF);
      chk("error_count", {48'd0, error_count}, 64'(m_errs));
      chk("protocol_fault", {63'd0, protocol_fault}, {63'd0, m_fault});
      chk("resp_tvalid", {63'd0, resp_tvalid}, {63'd0, m_pend});
      if (m_pend) chk("resp_tdata", resp_tdata, m_resp);
      if (m_pend || m_left > 0) chk("req_tready_busy", {63'd0, req_tready}, 64'd0);

      if (din_tvalid && m_left == 0) m_fault = 1;
      if (req_tvalid && req_tready) begin
        longint len;
        len = longint'(req_tdata[31:0]);
        m_resp_err    = (len == 0) || (len > longint'(MAXL));
        m_resp        = {15'd0, m_resp_err, req_tdata[47:32], m_resp_err ? 32'd0 : req_tdata[31:0]};
        m_beats_grant = (len + DW/8 - 1) / (DW/8);
        m_pend        = 1;
      end
      if (resp_tvalid && resp_tready) begin
        last_resp = resp_tdata;
        m_pend    = 0;
        if (m_resp_err) begin
          if (m_errs < 16'hFFFF) m_errs++;
        end else m_left = m_beats_grant;
      end
      if (din_tvalid && din_tready) begin
        mq.push_back({m_left == 1, din_tdata});
        m_left--;
        if (m_left == 0) m_frames++;
      end
      if (clear_stat) begin
        m_frames = 0; m_errs = 0; m_fault = 0;
      end
    end
  end

  task automatic send_req(input logic [31:0] len, input logic [15:0] id);
    bit ok;
    ok = 0;
    @(posedge ap_clk); #1;
    req_tdata  = {16'hBEEF, id, len};
    req_tvalid = 1;
    for (int k = 0; k < 200; k++) begin
      @(negedge ap_clk);
      if (req_tready) begin ok = 1; break; end
    end
    if (!ok) timeout("req_handshake");
    @(posedge ap_clk); #1;
    req_tvalid = 0;
  endtask

  task automatic send_beat(input logic [DW-1:0] d);
    bit ok;
    ok = 0;
    @(posedge ap_clk); #1;
    din_tdata  = d;
    din_tvalid = 1;
    for (int k = 0; k < 200; k++) begin
      @(negedge ap_clk);
      if (din_tready) begin ok = 1; break; end
    end
    if (!ok) timeout("data_handshake");
    @(posedge ap_clk); #1;
    din_tvalid = 0;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 0;
    for (int k = 0; k < 400; k++) begin
      @(negedge ap_clk);
      if (!m_pend && mq.size() == 0) begin ok = 1; break; end
    end
    if (!ok) timeout("drain");
  endtask

  initial begin
    ap_rst_n = 0; req_tdata = '0; req_tvalid = 0; resp_tready = 1;
    din_tdata = '0; din_tvalid = 0; out_tready = 1; clear_stat = 0;
    repeat (3) @(posedge ap_clk);
    @(negedge ap_clk);
    chk("rst_req_tready", {63'd0, req_tready}, 64'd0);
    chk("rst_resp_tvalid", {63'd0, resp_tvalid}, 64'd0);
    chk("rst_data_tready", {63'd0, din_tready}, 64'd0);
    chk("rst_out_tvalid", {63'd0, out_tvalid}, 64'd0);
    chk("rst_counts", {16'd0, error_count, frame_count}, 64'd0);
    @(posedge ap_clk); #1 ap_rst_n = 1;

    // Normal 16-byte frame, response held back for a few cycles
    resp_tready = 0;
    send_req(32'd16, 16'h0005);
    @(negedge ap_clk);
    chk("t1_resp_latency", {63'd0, resp_tvalid}, 64'd1);
    chk("t1_resp_tdata", resp_tdata, 64'h0000_0005_0000_0010);
    chk("t1_stall_resp", {61'd0, stall_flags}, 64'd2);
    repeat (2) @(negedge ap_clk);
    @(posedge ap_clk); #1 resp_tready = 1;
    for (int i = 0; i < 4; i++) send_beat(32'hA0 + 32'(i));
    wait_idle();
    chk("t1_last_out", {31'd0, last_out}, {31'd0, 1'b1, 32'hA3});
    chk("t1_frame_count", {32'd0, frame_count}, 64'd1);

    // Zero length -> error response
    send_req(32'd0, 16'h0007);
    wait_idle();
    repeat (2) @(negedge ap_clk);
    chk("t2_resp", last_resp, 64'h0001_0007_0000_0000);
    chk("t2_error_count", {48'd0, error_count}, 64'd1);
    chk("t2_data_tready", {63'd0, din_tready}, 64'd0);
    chk("t2_idle", {63'd0, req_tready}, 64'd1);

    // Oversize request, then a legal 8-byte one
    send_req(MAXL + 32'd1, 16'h0009);
    wait_idle();
    chk("t3_resp_err", last_resp, 64'h0001_0009_0000_0000);
    chk("t3_error_count", {48'd0, error_count}, 64'd2);
    send_req(32'd8, 16'h000A);
    wait_idle();
    chk("t3_resp_ok", last_resp, 64'h0000_000A_0000_0008);
    send_beat(32'h1111_0000);
    send_beat(32'h1111_0001);
    wait_idle();
    chk("t3_frame_count", {32'd0, frame_count}, 64'd2);

    // Frame larger than the FIFO with downstream blocked
    out_tready = 0;
    send_req(32'(4*DEPTH + 8), 16'h000B);
    wait_idle();
    fork
      for (int i = 0; i < DEPTH + 2; i++) send_beat(32'h100 + 32'(i));
      begin
        repeat (50) @(negedge ap_clk);
        chk("t4_data_tready", {63'd0, din_tready}, 64'd0);
        chk("t4_stall_data", {63'd0, stall_flags[2]}, 64'd1);
        chk("t4_out_tvalid", {63'd0, out_tvalid}, 64'd1);
        @(posedge ap_clk); #1 out_tready = 1;
      end
    join
    wait_idle();
    chk("t4_last_out", {31'd0, last_out}, {31'd0, 1'b1, 32'h100 + 32'(DEPTH + 1)});
    chk("t4_frame_count", {32'd0, frame_count}, 64'd3);

    // Stray data while idle, then clear
    @(posedge ap_clk); #1 din_tvalid = 1;
    @(posedge ap_clk); #1 din_tvalid = 0;
    repeat (3) @(negedge ap_clk);
    chk("t5_fault_set", {63'd0, protocol_fault}, 64'd1);
    @(posedge ap_clk); #1 clear_stat = 1;
    @(posedge ap_clk); #1 clear_stat = 0;
    @(negedge ap_clk);
    chk("t5_fault_clr", {63'd0, protocol_fault}, 64'd0);
    chk("t5_counts_clr", {16'd0, error_count, frame_count}, 64'd0);

    // Reset in the middle of an 8-beat frame
    send_req(32'd32, 16'h000C);
    wait_idle();
    for (int i = 0; i < 3; i++) send_beat(32'hC0 + 32'(i));
    @(posedge ap_clk); #1 ap_rst_n = 0;
    @(negedge ap_clk);
    chk("t6_out_tvalid", {63'd0, out_tvalid}, 64'd0);
    chk("t6_data_tready", {63'd0, din_tready}, 64'd0);
    chk("t6_resp_tvalid", {63'd0, resp_tvalid}, 64'd0);
    @(posedge ap_clk); #1 ap_rst_n = 1;
    send_req(32'd8, 16'h000D);
    wait_idle();
    send_beat(32'hD0);
    send_beat(32'hD1);
    wait_idle();
    chk("t6_last_out", {31'd0, last_out}, {31'd0, 1'b1, 32'hD1});
    chk("t6_frame_count", {32'd0, frame_count}, 64'd1);

    repeat (3) @(negedge ap_clk);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
